// File: rtl/load_store_unit_if.sv
// Request/response and data_memory bus of the load/store unit.
// master = datapath + data_memory side, slave = load_store_unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_error;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_write, mem_address, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store front end for a 16-bit word memory with 1-cycle registered reads.
// Optional MISALIGN_TRAP_EN: misaligned word accesses respond with resp_error instead of aligning.
module load_store_unit (
    input  logic             clock,
    input  logic             reset_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RDDAT,
        ST_WR,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic        r_byte;
    logic        r_signed;
    logic [15:0] r_addr;
    logic [7:0]  r_wbyte;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_rdata;

    logic        w_accept;
    logic        w_trap;
    logic [7:0]  w_lane;
    logic [15:0] w_load_val;
    logic [15:0] w_merged;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

`ifdef MISALIGN_TRAP_EN
    logic r_error;
    assign w_trap         = w_accept && !bus.req_byte && bus.req_addr[0];
    assign bus.resp_error = r_error;
`else
    assign w_trap         = 1'b0;
    assign bus.resp_error = 1'b0;
`endif

    // Lane select, extension and read-modify-write merge all work on the word returned in RDDAT.
    assign w_lane     = r_addr[0] ? bus.mem_read_data[15:8] : bus.mem_read_data[7:0];
    assign w_load_val = r_byte ? {{8{r_signed & w_lane[7]}}, w_lane} : bus.mem_read_data;
    assign w_merged   = r_addr[0] ? {r_wbyte, bus.mem_read_data[7:0]}
                                  : {bus.mem_read_data[15:8], r_wbyte};

    assign bus.mem_address    = {1'b0, r_addr[15:1]};
    assign bus.mem_write_data = r_mem_wdata;
    assign bus.resp_rdata     = r_rdata;

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    if (w_trap) begin
                        w_next = ST_RESP;
                    end else if (bus.req_write && !bus.req_byte) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD: begin
                w_next = ST_RDDAT;
            end
            ST_RDDAT: begin
                w_next = r_write ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                bus.mem_write = 1'b1;
                w_next        = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                w_next         = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write     <= 1'b0;
            r_byte      <= 1'b0;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_wbyte     <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
`ifdef MISALIGN_TRAP_EN
            r_error     <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_byte   <= bus.req_byte;
                r_signed <= bus.req_signed;
                r_addr   <= bus.req_addr;
                r_wbyte  <= bus.req_wdata[7:0];
                // Word stores go straight to WR; byte stores overwrite this with the merged word.
                if (bus.req_write) begin
                    r_mem_wdata <= bus.req_wdata;
                end
`ifdef MISALIGN_TRAP_EN
                r_error <= w_trap;
`endif
            end
            if (r_state == ST_RDDAT) begin
                if (r_write) begin
                    r_mem_wdata <= w_merged;
                end else begin
                    r_rdata <= w_load_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, randomized back-to-back traffic
// against a byte-level reference model, and a reset injected mid byte-store.
module tb_load_store_unit;
    logic clock;
    logic reset_n;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Behavioural data_memory seen by the unit: registered read, synchronous write.
    bit [15:0] env_mem [32768];
    always @(posedge clock) begin
        if (bus.mem_write) env_mem[bus.mem_address[14:0]] <= bus.mem_write_data;
        bus.mem_read_data <= env_mem[bus.mem_address[14:0]];
    end

    // Reference contents and last load result as the unit's user expects them.
    bit [15:0] ref_mem [32768];
    logic [15:0] ref_rdata;
    logic [15:0] obs_rdata;
    bit hold_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic prev_resp;
    always @(negedge clock) begin
        if (reset_n && prev_resp) check("resp_twice", bus.resp_valid, 1'b0);
        prev_resp <= reset_n && bus.resp_valid;
    end

    task automatic drive_junk();
        bus.req_valid  = hold_valid;
        bus.req_write  = 1'($urandom);
        bus.req_byte   = 1'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = 16'($urandom);
        bus.req_wdata  = 16'($urandom);
    endtask

    // Issue one request (called at a negedge) and check the whole transaction.
    task automatic do_op(input bit wr, input bit by, input bit sg,
                         input logic [15:0] addr, input logic [15:0] wd);
        int k;
        int n_wr;
        int exp_lat;
        bit trap;
        bit exp_err;
        logic [14:0] idx;
        logic [7:0]  lane;
        logic [15:0] exp_word;

        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = !by && addr[0];
`endif
        idx     = addr[15:1];
        exp_err = trap;
        if (trap) begin
            exp_lat = 1;
        end else if (wr) begin
            if (by) begin
                if (addr[0]) ref_mem[idx][15:8] = wd[7:0];
                else         ref_mem[idx][7:0]  = wd[7:0];
                exp_lat = 4;
            end else begin
                ref_mem[idx] = wd;
                exp_lat = 2;
            end
        end else begin
            if (by) begin
                lane      = addr[0] ? ref_mem[idx][15:8] : ref_mem[idx][7:0];
                ref_rdata = {(sg && lane[7]) ? 8'hFF : 8'h00, lane};
            end else begin
                ref_rdata = ref_mem[idx];
            end
            exp_lat = 3;
        end
        exp_word = ref_mem[idx];

        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_byte   = by;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;

        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", bus.req_ready, 1'b1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 drive_junk();

        n_wr = 0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1 && !trap && !(wr && !by))
                check("rd_address", bus.mem_address, {1'b0, addr[15:1]});
            if (bus.mem_write) begin
                n_wr++;
                check("wr_address", bus.mem_address, {1'b0, addr[15:1]});
                check("wr_data", bus.mem_write_data, exp_word);
            end
            if (bus.resp_valid) break;
            check("busy_ready", bus.req_ready, 1'b0);
        end
        check("latency", k, exp_lat);
        check("resp_ready", bus.req_ready, 1'b0);
        check("mem_writes", n_wr, (wr && !trap) ? 1 : 0);
        check("resp_error", bus.resp_error, exp_err);
        check("resp_rdata", bus.resp_rdata, ref_rdata);
        obs_rdata = bus.resp_rdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_write"}, bus.mem_write, 1'b0);
        check({tag, "_mem_address"}, bus.mem_address, 16'h0000);
        check({tag, "_mem_wdata"}, bus.mem_write_data, 16'h0000);
        check({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 16'h0000);
        check({tag, "_resp_error"}, bus.resp_error, 1'b0);
        check({tag, "_req_ready"}, bus.req_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        logic [15:0] a;
        reset_n    = 1'b0;
        hold_valid = 1'b0;
        ref_rdata  = '0;
        prev_resp  = 1'b0;
        drive_junk();
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Directed cases.
        do_op(1'b1, 1'b0, 1'b0, 16'h0004, 16'hBEEF);
        do_op(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000);
        check("t2_word_load", obs_rdata, 16'hBEEF);
        do_op(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0080);
        do_op(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000);
        check("t3_merged_word", obs_rdata, 16'h80EF);
        do_op(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000);
        check("t3_hi_signed", obs_rdata, 16'hFF80);
        do_op(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        check("t3_hi_unsigned", obs_rdata, 16'h0080);
        do_op(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0000);
        check("t3_lo_signed", obs_rdata, 16'hFFEF);
        do_op(1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234);
        do_op(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
`ifndef MISALIGN_TRAP_EN
        check("t6_aligned_read", obs_rdata, 16'h1234);
`endif
        do_op(1'b1, 1'b0, 1'b0, 16'h0007, 16'h5A5A);

        // Randomized traffic with req_valid held high through busy cycles.
        hold_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            do_op(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end

        // Reset asserted while a byte store is in WR.
        hold_valid = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_byte   = 1'b1;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0011;
        bus.req_wdata  = 16'h00C3;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        @(posedge clock);
        #1 drive_junk();
        k = 0;
        while (!bus.mem_write && k < 8) begin
            @(negedge clock);
            k++;
        end
        check("rst_reached_wr", bus.mem_write, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        ref_rdata = '0;
        @(negedge clock);
        check_reset_outputs("midreset_held");
        reset_n = 1'b1;
        @(negedge clock);

        // Restore a known value at the aborted word, then confirm normal service.
        do_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'hA55A);
        do_op(1'b1, 1'b1, 1'b0, 16'h0011, 16'h00C3);
        do_op(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        check("post_reset_word", obs_rdata, 16'hC35A);
        do_op(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000);
        check("post_reset_signed", obs_rdata, 16'hFFC3);

        bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
